// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: count width and parameter legality.
package fifo_pkg;

  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(int width, int depth, int af_level, int ae_level);
    return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, contents never reset.
module fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags, error pulses and optional FWFT read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_i,
  input  logic [WIDTH-1:0]          din_i,
  input  logic                      rd_i,
  output logic [WIDTH-1:0]          dout_o,
  output logic                      rd_valid_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_w(DEPTH);

  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfC    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeC    = CntW'(AE_LEVEL);

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
    $fatal(1, "sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             empty, full;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] ram_rdata;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DepthC);
  assign rd_acc = rd_i && !empty;
  // A full FIFO still takes a write when the same edge frees a slot.
  assign wr_acc = wr_i && (!full || rd_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + PtrW'(1);
    if (rd_acc) rptr_d = rptr_q + PtrW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_i && !wr_acc;
      underflow_q <= rd_i && empty;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wptr_q),
    .wdata_i (din_i),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign dout_o     = ram_rdata;
    assign rd_valid_o = !empty;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) dout_q <= ram_rdata;
      end
    end

    assign dout_o     = dout_q;
    assign rd_valid_o = rd_valid_q;
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AfC);
  assign almost_empty_o = (count_q <= AeC);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's 8-bit x 16 FIFO. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, overflow and underflow pulses, and a first-word-fall-through (FWFT) mode. It sits between a single-clock producer and consumer anywhere in the datapath and is the default buffering block for new designs.

## Interface
- WIDTH, default 8: data word width in bits, 1 or more.
- DEPTH, default 16: number of entries; must be a power of two, 2 or more.
- AF_LEVEL, default DEPTH-2: `almost_full` asserts when count is at least AF_LEVEL.
- AE_LEVEL, default 2: `almost_empty` asserts when count is at most AE_LEVEL.
- FWFT, default 0: 0 = standard registered read; 1 = first-word-fall-through.
- clk, in, 1: clock; all state changes on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- wr, in, 1: write request.
- din, in, WIDTH: write data, sampled with `wr`.
- rd, in, 1: read request (FWFT=1: pop/acknowledge of the head word).
- dout, out, WIDTH: read data.
- rd_valid, out, 1: `dout` holds valid data (see Timing).
- full, out, 1: count == DEPTH.
- empty, out, 1: count == 0.
- almost_full, out, 1: count >= AF_LEVEL.
- almost_empty, out, 1: count <= AE_LEVEL.
- count, out, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow, out, 1: one-cycle pulse when a write is rejected.
- underflow, out, 1: one-cycle pulse when a read is rejected.

## Operation
- Pointers `wptr` and `rptr` are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. `count` is a separate register.
- Acceptance is evaluated on the same edge, using pre-edge state:
  - Read accepted (rd_acc) = rd && !empty.
  - Write accepted (wr_acc) = wr && (!full || rd_acc).
  - Writing into a full FIFO with a simultaneous read is therefore allowed; count stays at DEPTH.
- Count update: +1 for write only; -1 for read only; unchanged for both or neither.
- Empty FIFO with rd && wr: the write is accepted, the read is rejected, `underflow` pulses, and count becomes 1. There is no bypass of data straight from write to read.
- `overflow` = wr && !wr_acc. `underflow` = rd && empty. Both are registered and pulse for the cycle after the offending edge.
- `full`, `empty`, `almost_full` and `almost_empty` decode combinationally from the registered `count`.
- Memory contents are not reset; only pointers, count and output registers are.
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0 (given AF_LEVEL > 0), dout 0, rd_valid 0, overflow 0, underflow 0.
- Reset mid-operation discards all contents. Any `wr` or `rd` in the reset cycle is ignored and raises no pulse.

## Timing
- Write: data accepted at edge N is stored at `mem[wptr]`. Count and flags update after edge N.
- FWFT=0:
  - A read accepted at edge N loads `dout` from `mem[rptr]` and sets `rd_valid` = 1 after edge N, for one cycle per read.
  - `dout` holds its value until the next accepted read.
  - Write-to-readable latency is 1 cycle (empty low after edge N, `rd` at edge N+1, data visible after N+1).
- FWFT=1:
  - `dout` = `mem[rptr]` combinationally and `rd_valid` = !empty.
  - A word written at edge N appears on `dout` after edge N.
  - `rd` at edge M advances to the next word after edge M.
  - `dout` is don't-care while empty.
- Flag latency is 0 cycles after the count edge; there are no stale flags.

## Structure
- Package `fifo_pkg`:
  - `function automatic int cnt_w(int depth)` returning $clog2(depth)+1.
  - An elaboration-time parameter check (DEPTH power of two, AE_LEVEL < AF_LEVEL <= DEPTH) that issues `$fatal` on violation.
- Sub-module `fifo_ram`: WIDTH x DEPTH array with one synchronous write port and one asynchronous read port. The parent registers `dout` when FWFT=0.
- Top module `sync_fifo_param` holds the pointer, count and flag logic plus the FWFT generate branch.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2 unless stated.
- Reset: drive `rst` for 2 cycles with `wr`=`rd`=1 -> count 0, empty 1, almost_empty 1, full 0, dout 0, no overflow or underflow pulse.
- Fill, then overflow: write 0x00..0x0F:
  - almost_empty deasserts at count 3.
  - almost_full asserts at count 14.
  - full asserts at count 16.
  - A 17th write of 0xAA -> overflow pulses once and count stays 16.
- Drain and wrap (FWFT=0):
  - Read 16 times -> dout 0x00..0x0F, each 1 cycle after its rd, with rd_valid high.
  - Then write 0x20..0x27 and read 8 times across the pointer wrap -> 0x20..0x27 in order.
- Simultaneous read and write:
  - At full, wr=rd=1 with din 0x55 -> count stays 16, oldest word read out, 0x55 later read last.
  - At empty, wr=rd=1 -> count 1, underflow pulses.
- FWFT=1: write 0x3C to empty FIFO -> dout 0x3C and rd_valid 1 the next cycle with no rd issued; rd -> empty 1, rd_valid 0.
- Reset mid-stream: with count 9, assert `rst` for 1 cycle -> count 0, empty 1; then write 0x77 and read -> 0x77, with no old data leaking out.
